qtrn: RTL

Parametrised successor to the quad QTR-RC reflectance interface. It drives NCH sensor pins high to charge each sensor capacitor, then times every channel's discharge in 10 µs ticks. From those times it produces a per-channel 8-bit raw count and a thresholded black/white bitmap. It sits on the peripheral bus daisy chain like every other peripheral and can autosend results every sample, or only when the bitmap changes.

---
 rtl/qtrn.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/qtrn.sv
// qtrn: NCH-channel RC reflectance sensor interface on the peripheral bus.
// Charges sensor pins, times each discharge in 10 us ticks, publishes raw counts and a thresholded bitmap.
module qtrn #(
  parameter int NCH       = 4,
  parameter int CHG_TICKS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rdwr,
  input  logic             strobe,
  input  logic [3:0]       our_addr,
  input  logic [11:0]      addr,
  input  logic             busy_in,
  output logic             busy_out,
  input  logic             addr_match_in,
  output logic             addr_match_out,
  input  logic [7:0]       datin,
  output logic [7:0]       datout,
  input  logic             m10clk,
  input  logic             u10clk,
  inout  wire  [NCH-1:0]   q
);

  typedef enum logic [1:0] {IDLE, CHARGE, MEASURE, PUBLISH} state_t;

  state_t         state_reg, state_next;
  logic [NCH-1:0] q_s1_reg, q_s2_reg;
  logic [3:0]     pcnt_reg, pcnt_next;
  logic [3:0]     chg_reg, chg_next;
  logic [7:0]     timer_reg, timer_next;
  logic [NCH-1:0] done_reg, done_next;
  logic [7:0]     work_reg  [NCH];
  logic [7:0]     work_next [NCH];
  logic [7:0]     raw_reg   [NCH];
  logic [NCH-1:0] bitmap_reg;
  logic [NCH-1:0] new_bitmap;
  logic [NCH-1:0] hit;
  logic [7:0]     sens_reg;
  logic [3:0]     poll_reg;
  logic [1:0]     ctrl_reg;
  logic           avail_reg;

  logic           myaddr;
  logic [3:0]     idx;
  logic           wr_hit, rd_hit;
  logic           all_done, exit_meas;
  logic [7:0]     rd_data;

  assign myaddr         = (addr[11:8] == our_addr) && (addr[7:4] == 4'h0);
  assign idx            = addr[3:0];
  assign wr_hit         = myaddr & strobe & ~rdwr;
  assign rd_hit         = myaddr & strobe & rdwr;
  assign busy_out       = busy_in;
  assign addr_match_out = myaddr | addr_match_in;

  assign q = (state_reg == CHARGE) ? {NCH{1'b1}} : {NCH{1'bz}};

  always_ff @(posedge clk) begin
    if (reset) begin
      q_s1_reg <= '0;
      q_s2_reg <= '0;
    end else begin
      q_s1_reg <= q;
      q_s2_reg <= q_s1_reg;
    end
  end

  // A channel finishes the first tick its synchronized pin reads low.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign hit[gi]        = ~done_reg[gi] & ~q_s2_reg[gi];
    assign new_bitmap[gi] = work_reg[gi] > sens_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        work_reg[gi] <= 8'h00;
        raw_reg[gi]  <= 8'h00;
      end else begin
        work_reg[gi] <= work_next[gi];
        if (state_reg == PUBLISH)
          raw_reg[gi] <= work_reg[gi];
      end
    end
  end

  assign all_done  = &(done_reg | hit);
  assign exit_meas = all_done || (timer_reg == 8'hFF);

  always_comb begin
    state_next = state_reg;
    pcnt_next  = pcnt_reg;
    chg_next   = chg_reg;
    timer_next = timer_reg;
    done_next  = done_reg;
    work_next  = work_reg;
    case (state_reg)
      IDLE: begin
        chg_next = 4'd0;
        if (m10clk && (poll_reg != 4'd0)) begin
          if (pcnt_reg == poll_reg) begin
            state_next = CHARGE;
            pcnt_next  = 4'd1;
          end else begin
            pcnt_next = pcnt_reg + 4'd1;
          end
        end
      end
      CHARGE: begin
        if (u10clk) begin
          if (chg_reg == 4'(CHG_TICKS - 1)) begin
            state_next = MEASURE;
            timer_next = 8'd0;
            done_next  = '0;
          end else begin
            chg_next = chg_reg + 4'd1;
          end
        end
      end
      MEASURE: begin
        if (u10clk) begin
          for (int i = 0; i < NCH; i++)
            if (hit[i]) work_next[i] = timer_reg;
          done_next = done_reg | hit;
          if (timer_reg != 8'hFF)
            timer_next = timer_reg + 8'd1;
          if (exit_meas) begin
            state_next = PUBLISH;
            for (int i = 0; i < NCH; i++)
              if (!(done_reg[i] | hit[i])) work_next[i] = 8'hFF;
          end
        end
      end
      PUBLISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      pcnt_reg  <= 4'd1;
      chg_reg   <= 4'd0;
      timer_reg <= 8'd0;
      done_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pcnt_reg  <= pcnt_next;
      chg_reg   <= chg_next;
      timer_reg <= timer_next;
      done_reg  <= done_next;
    end
  end

  // The publish assignment to avail follows the read clear so a coincident PUBLISH wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      bitmap_reg <= '0;
      sens_reg   <= 8'd1;
      poll_reg   <= 4'd0;
      ctrl_reg   <= 2'd0;
      avail_reg  <= 1'b0;
    end else begin
      if (wr_hit) begin
        case (idx)
          4'd1:    sens_reg <= datin;
          4'd2:    poll_reg <= datin[3:0];
          4'd3:    ctrl_reg <= datin[1:0];
          default: ;
        endcase
      end
      if (rd_hit)
        avail_reg <= 1'b0;
      if (state_reg == PUBLISH) begin
        bitmap_reg <= new_bitmap;
        if (!(ctrl_reg[0] && (new_bitmap == bitmap_reg)))
          avail_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (idx)
      4'd0:    rd_data[NCH-1:0] = bitmap_reg;
      4'd1:    rd_data = sens_reg;
      4'd2:    rd_data = {4'h0, poll_reg};
      4'd3:    rd_data = {6'h00, ctrl_reg};
      default: begin
        for (int i = 0; i < NCH; i++)
          if (idx == 4'(4 + i)) rd_data = raw_reg[i];
      end
    endcase
  end

  always_comb begin
    datout = datin;
    if (rd_hit)
      datout = rd_data;
    else if (myaddr && !strobe && avail_reg)
      datout = ctrl_reg[1] ? 8'(1 + NCH) : 8'h01;
  end

endmodule
